// File: rtl/kn_row_fetch.sv
// kn_row_fetch: sweeps k rows of the KxN weight SRAM and streams each assembled row out with backpressure
module kn_row_fetch #(
  parameter int KMAX   = 1024,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX),
  parameter int N_W    = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [K_W-1:0]      cmd_k_base,
  input  logic [K_W:0]        cmd_k_cnt,
  output logic                x_en,
  output logic                x_re,
  output logic                x_we,
  output logic [K_W-1:0]      x_k,
  output logic [N_W-1:0]      x_n,
  output logic [DATA_W-1:0]   x_wdata,
  output logic [BYTE_W-1:0]   x_wmask,
  input  logic [DATA_W-1:0]   x_rdata,
  input  logic                x_rvalid,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [N*DATA_W-1:0] row_data,
  output logic [K_W-1:0]      row_k,
  output logic                row_last,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [K_W:0]   KMAX_C = (K_W+1)'(KMAX);
  localparam logic [K_W:0]   ONE    = (K_W+1)'(1);
  localparam logic [K_W-1:0] KLAST  = (K_W)'(KMAX - 1);
  localparam logic [N_W-1:0] NLAST  = (N_W)'(N - 1);
  state_t                       state_q, state_d;
  logic [K_W-1:0]               k_cur_q, k_cur_d;
  logic [K_W:0]                 rows_left_q, rows_left_d;
  logic [N_W-1:0]               n_iss_q, n_iss_d;
  logic                         tag_v_q, tag_v_d;
  logic [N_W-1:0]               tag_lane_q, tag_lane_d;
  logic [K_W-1:0]               tag_k_q, tag_k_d;
  logic                         tag_last_q, tag_last_d;
  logic [N-1:0][DATA_W-1:0]     asm_q, asm_d;
  logic                         asm_full_q, asm_full_d;
  logic [K_W-1:0]               asm_k_q, asm_k_d;
  logic                         asm_last_q, asm_last_d;
  logic                         row_valid_q, row_valid_d;
  logic [N-1:0][DATA_W-1:0]     row_data_q, row_data_d;
  logic [K_W-1:0]               row_k_q, row_k_d;
  logic                         row_last_q, row_last_d;
  logic [K_W:0]                 cnt_clip;
  logic                         xfer, issue;
  assign cnt_clip  = (cmd_k_cnt > KMAX_C) ? KMAX_C : cmd_k_cnt;
  assign xfer      = asm_full_q && (!row_valid_q || row_ready);
  assign issue     = (state_q == ISSUE) && ((n_iss_q != '0) || (!tag_v_q && (!asm_full_q || xfer)));
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign x_en      = issue;
  assign x_re      = issue;
  assign x_we      = 1'b0;
  assign x_k       = k_cur_q;
  assign x_n       = n_iss_q;
  assign x_wdata   = '0;
  assign x_wmask   = '0;
  assign row_valid = row_valid_q;
  assign row_data  = row_data_q;
  assign row_k     = row_k_q;
  assign row_last  = row_last_q;
  // Next state: command sequencing, read issue/tagging, row assembly and output transfer
  always_comb begin
    state_d     = state_q;
    k_cur_d     = k_cur_q;
    rows_left_d = rows_left_q;
    n_iss_d     = n_iss_q;
    tag_v_d     = issue;
    tag_lane_d  = n_iss_q;
    tag_k_d     = k_cur_q;
    tag_last_d  = (rows_left_q == ONE);
    asm_d       = asm_q;
    asm_full_d  = xfer ? 1'b0 : asm_full_q;
    asm_k_d     = asm_k_q;
    asm_last_d  = asm_last_q;
    row_valid_d = xfer || (row_valid_q && !row_ready);
    row_data_d  = xfer ? asm_q : row_data_q;
    row_k_d     = xfer ? asm_k_q : row_k_q;
    row_last_d  = xfer ? asm_last_q : row_last_q;
    if (x_rvalid && tag_v_q) begin
      asm_d[tag_lane_q] = x_rdata;
      if (tag_lane_q == NLAST) begin
        asm_full_d = 1'b1;
        asm_k_d    = tag_k_q;
        asm_last_d = tag_last_q;
      end
    end
    if (state_q == IDLE && cmd_valid) begin
      state_d     = (cnt_clip == '0) ? DONE : ISSUE;
      k_cur_d     = cmd_k_base;
      rows_left_d = cnt_clip;
      n_iss_d     = '0;
    end else if (issue) begin
      n_iss_d = (n_iss_q == NLAST) ? '0 : n_iss_q + 1'b1;
      if (n_iss_q == NLAST) begin
        rows_left_d = rows_left_q - ONE;
        k_cur_d     = (k_cur_q == KLAST) ? '0 : k_cur_q + 1'b1;
        state_d     = (rows_left_q == ONE) ? DRAIN : ISSUE;
      end
    end else if (state_q == DRAIN && row_valid_q && row_ready && row_last_q) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // Register all state; active-low synchronous reset clears everything including partial rows and tags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_cur_q     <= '0;
      rows_left_q <= '0;
      n_iss_q     <= '0;
      tag_v_q     <= 1'b0;
      tag_lane_q  <= '0;
      tag_k_q     <= '0;
      tag_last_q  <= 1'b0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      asm_k_q     <= '0;
      asm_last_q  <= 1'b0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_k_q     <= '0;
      row_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cur_q     <= k_cur_d;
      rows_left_q <= rows_left_d;
      n_iss_q     <= n_iss_d;
      tag_v_q     <= tag_v_d;
      tag_lane_q  <= tag_lane_d;
      tag_k_q     <= tag_k_d;
      tag_last_q  <= tag_last_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      asm_k_q     <= asm_k_d;
      asm_last_q  <= asm_last_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_k_q     <= row_k_d;
      row_last_q  <= row_last_d;
    end
  end
endmodule

// File: doc/kn_row_fetch.md
# kn_row_fetch

Read sequencer that sits directly downstream of the K×N weight SRAM (`sram_mem_kn`). It drives that SRAM's x_* read port and sweeps a contiguous range of k rows, reading all N words of each row one per cycle. It assembles each row into an N-lane vector and hands it to the MAC array over a valid/ready stream with backpressure. One command describes one sweep, and the block reports completion with a single-cycle done pulse.

## Interface
- KMAX, 1024: number of k rows in the SRAM.
- N, 8: words per row (lanes).
- DATA_W, 32: word width.
- BYTE_W, DATA_W/8: write-mask width of the SRAM port.
- K_W, (KMAX<=1)?1:$clog2(KMAX): k index width.
- N_W, (N<=1)?1:$clog2(N): n index width.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_k_base  in  K_W  first row.
- cmd_k_cnt  in  K_W+1  number of rows, 0..KMAX.
- x_en, x_re  out  1  read strobe to SRAM; both equal to "issue this cycle".
- x_we  out  1  constant 0.
- x_k  out  K_W  row being read.
- x_n  out  N_W  lane being read.
- x_wdata  out  DATA_W  constant 0.
- x_wmask  out  BYTE_W  constant 0.
- x_rdata  in  DATA_W  SRAM read data.
- x_rvalid  in  1  SRAM read data valid, exactly one cycle after x_en&&x_re.
- row_valid  out  1  row output valid.
- row_ready  in  1  consumer accepts.
- row_data  out  N*DATA_W  lane n at bits [n*DATA_W +: DATA_W].
- row_k  out  K_W  k of row_data.
- row_last  out  1  row_data is the final row of the command.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: cmd_valid && cmd_ready accepts. Latches k_cur=cmd_k_base and rows_left=cmd_k_cnt, clears issue lane n_iss. Goes to DONE if cmd_k_cnt==0, else to ISSUE.
  - ISSUE: issues reads (k_cur, n_iss) while issue is permitted. After issuing n_iss==N-1:
    - n_iss returns to 0 and rows_left decrements.
    - k_cur becomes (k_cur==KMAX-1) ? 0 : k_cur+1.
    - When rows_left reaches 0, the next state is DRAIN.
  - DRAIN: waits until the final row is accepted (row_valid && row_ready && row_last), then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Issue permission in a cycle:
  - (n_iss!=0), or
  - (n_iss==0 and no read outstanding and (asm_full==0 or an asm→out transfer occurs this cycle)).
- Assembly:
  - Each issue registers a tag {lane, k, last_row}.
  - On x_rvalid with a tag outstanding, x_rdata is written to asm lane tag.lane.
  - The lane N-1 write sets asm_full and records asm_k and asm_last.
  - x_rvalid with no tag outstanding is ignored.
- Transfer:
  - Occurs in a cycle where asm_full && (!row_valid || row_ready).
  - Copies asm to the output registers, sets row_valid=1, clears asm_full.
  - Otherwise row_valid falls after row_valid && row_ready.
- Output stability: row_data, row_k and row_last stay stable while row_valid && !row_ready.
- Commands offered outside IDLE are not accepted and have no effect.

## Timing
- Reset values (after an edge with rst=0):
  - state IDLE, so cmd_ready=1 and busy=0.
  - row_valid=0, done=0, x_en=x_re=0.
  - asm_full=0, tags cleared.
  - row_data, row_k and row_last are 0.
- Per row:
  - Reads are issued on cycles c..c+N-1.
  - The last response arrives on c+N and asm_full is set from c+N+1.
  - The transfer on c+N+1 makes row_valid=1 from c+N+2.
  - The next row's lane 0 may issue at c+N+1 if that transfer occurs.
  - Steady-state period with row_ready=1 is N+1 cycles per row.
- Command to first read: a command accepted at cycle t issues lane 0 at t+1.
- Done timing:
  - done pulses the cycle after the last row handshake.
  - For k_cnt==0, done pulses at t+1 after acceptance at t.
- k wraps modulo KMAX; cmd_k_cnt > KMAX is clipped to KMAX.
- Reset mid-operation:
  - All state clears at that edge.
  - A response to a pre-reset read arrives with no tag and is dropped.
  - Partial rows are discarded and no row_valid is produced.

## Test plan
- **Basic sweep.** Preload word(k,n)=k*16+n, N=8, row_ready=1, cmd k_base=3, cnt=2.
  - Rows k=3 {0x30..0x37} and k=4 {0x40..0x47}.
  - row_last only on the 2nd row; done one cycle after it.
  - x_en high 16 cycles total, row_valid rising edges 9 cycles apart.
- **Backpressure.** cnt=3, row_ready=0 for 30 cycles after the first row_valid.
  - Row k=base stays stable.
  - Exactly one further row completes into asm, then issue stops (x_en=0).
  - On release, rows come out in order, none lost or duplicated.
- **Wrap.** k_base=1023, cnt=2.
  - x_k sequence is 1023 (x8) then 0 (x8).
  - row_k = 1023, 0.
- **Zero count.** cnt=0 accepted at t.
  - done=1 at t+1, cmd_ready=1 at t+2.
  - x_en and row_valid never assert.
- **Reset mid-row.** rst=0 on the cycle lane 4 of the first row issues.
  - Next cycle: x_en=0, row_valid=0, busy=0, cmd_ready=1.
  - The stray x_rvalid is ignored.
  - A fresh cmd k_base=5, cnt=1 returns {0x50..0x57}.
- **Busy command.** cmd_valid held high with a new command during ISSUE.
  - Not accepted (cmd_ready=0).
  - The current sweep is unaffected.
  - The command is accepted on the cycle after done.
